// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES round sequencer, one round per cycle over an external round datapath
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic         iStart,
    output logic         oReady,
    input  logic [127:0] iPlaintext,
    output logic [3:0]   oRoundIdx,
    input  logic [127:0] iRoundKey,
    output logic [127:0] oRndState,
    output logic [127:0] oRndKey,
    output logic         oFinalRound,
    input  logic [127:0] iRndResult,
    input  logic         iAbort,
    output logic         oValid,
    output logic [127:0] oCiphertext,
    input  logic         iAck
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;
    localparam logic [3:0] NR_L = 4'(NR);
    state_e       state_q;
    logic [3:0]   rnd_q;
    logic [127:0] data_q;
    logic [127:0] ct_q;
    // Sequencer: key-0 whitening on accept, one round per cycle, result held until ack or abort
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            data_q  <= '0;
            ct_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (iStart) begin
                    data_q  <= iPlaintext ^ iRoundKey;
                    rnd_q   <= 4'd1;
                    state_q <= ROUND;
                end
                ROUND: if (iAbort) begin
                    rnd_q   <= '0;
                    state_q <= IDLE;
                end else begin
                    data_q <= iRndResult;
                    if (rnd_q == NR_L) begin
                        ct_q    <= iRndResult;
                        state_q <= DONE;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                DONE: if (iAck || iAbort) begin
                    rnd_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign oReady      = state_q == IDLE;
    assign oValid      = state_q == DONE;
    assign oRoundIdx   = state_q == ROUND ? rnd_q : 4'd0;
    assign oFinalRound = state_q == ROUND && rnd_q == NR_L;
    assign oRndState   = data_q;
    assign oRndKey     = iRoundKey;
    assign oCiphertext = ct_q;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: drives AES-128 and AES-256 controllers over a behavioural AES round and key schedule
module tb_aes_round_ctrl;
    logic         clk, rst_n, st, ab, ack, b_st, b_ack;
    logic [127:0] pt;
    logic         a_rdy, a_vld, a_fin, b_rdy, b_vld, b_fin;
    logic [3:0]   a_idx, b_idx;
    logic [127:0] a_rk, a_rs, a_key, a_res, a_ct, b_rk, b_rs, b_key, b_res, b_ct;
    logic [7:0]   sbox [256];
    logic [127:0] rk [2][15];
    int           n_chk, n_err;

    aes_round_ctrl #(.NR(10)) dut10 (
        .iClk(clk), .iRst_n(rst_n), .iStart(st), .oReady(a_rdy), .iPlaintext(pt),
        .oRoundIdx(a_idx), .iRoundKey(a_rk), .oRndState(a_rs), .oRndKey(a_key),
        .oFinalRound(a_fin), .iRndResult(a_res), .iAbort(ab), .oValid(a_vld),
        .oCiphertext(a_ct), .iAck(ack)
    );
    aes_round_ctrl #(.NR(14)) dut14 (
        .iClk(clk), .iRst_n(rst_n), .iStart(b_st), .oReady(b_rdy), .iPlaintext(pt),
        .oRoundIdx(b_idx), .iRoundKey(b_rk), .oRndState(b_rs), .oRndKey(b_key),
        .oFinalRound(b_fin), .iRndResult(b_res), .iAbort(1'b0), .oValid(b_vld),
        .oCiphertext(b_ct), .iAck(b_ack)
    );

    function automatic logic [7:0] xt(logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] v, int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] gb(logic [127:0] s, int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [31:0] subw(logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // One AES round: SubBytes, ShiftRows, MixColumns unless final, AddRoundKey
    function automatic logic [127:0] aes_round(logic [127:0] s, logic [127:0] k, logic fin);
        logic [127:0] t;
        logic [7:0]   a0, a1, a2, a3;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[127-8*(r+4*c) -: 8] = sbox[gb(s, r + 4*((c + r) % 4))];
        if (!fin)
            for (int c = 0; c < 4; c++) begin
                a0 = gb(t, 4*c); a1 = gb(t, 4*c+1); a2 = gb(t, 4*c+2); a3 = gb(t, 4*c+3);
                t[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                     xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
            end
        return t ^ k;
    endfunction

    task automatic expand(input int which, input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        int          nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk[which][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] ref_enc(int which, logic [127:0] p);
        int           nr = which == 1 ? 14 : 10;
        logic [127:0] s = p ^ rk[which][0];
        for (int r = 1; r <= nr; r++) s = aes_round(s, rk[which][r], r == nr);
        return s;
    endfunction

    assign a_rk  = rk[0][a_idx];
    assign b_rk  = rk[1][b_idx];
    assign a_res = aes_round(a_rs, a_key, a_fin);
    assign b_res = aes_round(b_rs, b_key, b_fin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start an NR=10 operation and follow it to oValid, checking the round index each cycle
    task automatic op10(input logic [127:0] p, output int lat);
        pt = p;
        st = 1'b1;
        step();
        pt = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (!a_vld && lat < 40) begin
            chk("idx", 128'(a_idx), 128'(lat + 1));
            chk("final", 128'(a_fin), 128'(lat == 9));
            st = 1'($urandom_range(0, 1));
            step();
            lat++;
        end
        st = 1'b0;
    endtask

    task automatic ack10(input string tag);
        st = 1'b0;
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk({tag, "_vld"}, 128'(a_vld), 128'(0));
        chk({tag, "_rdy"}, 128'(a_rdy), 128'(1));
    endtask

    initial begin
        int           lat, n;
        bit           seen;
        logic [127:0] p, k, exp_ct;
        n_chk = 0; n_err = 0;
        rst_n = 1'b0; st = 1'b0; ab = 1'b0; ack = 1'b0; b_st = 1'b0; b_ack = 1'b0; pt = '0;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        expand(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

        // reset values
        step();
        chk("rst_rdy", 128'(a_rdy), 128'(1));
        chk("rst_vld", 128'(a_vld), 128'(0));
        chk("rst_ct", a_ct, 128'h0);
        chk("rst_state", a_rs, 128'h0);
        chk("rst_idx", 128'(a_idx), 128'(0));
        chk("rst_fin", 128'(a_fin), 128'(0));
        chk("rst_key", a_key, rk[0][0]);
        chk("rst_b_rdy", 128'(b_rdy), 128'(1));
        chk("rst_b_ct", b_ct, 128'h0);
        step();
        rst_n = 1'b1;

        // FIPS-197 C.1
        op10(128'h00112233445566778899aabbccddeeff, lat);
        chk("c1_lat", 128'(lat), 128'(10));
        chk("c1_ct", a_ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        exp_ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

        // backpressure: hold 20 cycles with iStart pulses
        for (int i = 0; i < 20; i++) begin
            st = 1'(i % 2);
            step();
            chk("hold_vld", 128'(a_vld), 128'(1));
            chk("hold_ct", a_ct, exp_ct);
        end
        ack10("c1_ack");

        // back-to-back with iAck held high
        ack = 1'b1;
        p = {$urandom, $urandom, $urandom, $urandom};
        op10(p, lat);
        chk("b2b1_lat", 128'(lat), 128'(10));
        chk("b2b1_ct", a_ct, ref_enc(0, p));
        step();
        chk("b2b_vld_fall", 128'(a_vld), 128'(0));
        chk("b2b_rdy", 128'(a_rdy), 128'(1));
        p = {$urandom, $urandom, $urandom, $urandom};
        op10(p, lat);
        chk("b2b2_lat", 128'(lat), 128'(10));
        chk("b2b2_ct", a_ct, ref_enc(0, p));
        step();
        ack = 1'b0;
        chk("b2b_end_rdy", 128'(a_rdy), 128'(1));

        // random keys and plaintexts, random hold, ack possibly with abort
        for (int i = 0; i < 6; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            expand(0, {k, 128'h0}, 4);
            op10(p, lat);
            exp_ct = ref_enc(0, p);
            chk("rnd_lat", 128'(lat), 128'(10));
            chk("rnd_ct", a_ct, exp_ct);
            chk("rnd_key", a_key, a_rk);
            repeat ($urandom_range(0, 3)) begin
                st = 1'b1;
                step();
                chk("rnd_hold", a_ct, exp_ct);
            end
            ab = 1'($urandom_range(0, 1));
            ack10("rnd_ack");
            ab = 1'b0;
        end

        // abort at round 5
        pt = {$urandom, $urandom, $urandom, $urandom};
        st = 1'b1;
        step();
        st = 1'b0;
        n = 0;
        while (a_idx != 4'd5 && n < 20) begin step(); n++; end
        chk("ab5_reach", 128'(a_idx), 128'(5));
        ab = 1'b1;
        step();
        ab = 1'b0;
        chk("ab5_rdy", 128'(a_rdy), 128'(1));
        chk("ab5_vld", 128'(a_vld), 128'(0));
        chk("ab5_ct", a_ct, exp_ct);
        seen = 1'b0;
        repeat (15) begin step(); seen |= a_vld; end
        chk("ab5_novld", 128'(seen), 128'(0));
        p = {$urandom, $urandom, $urandom, $urandom};
        op10(p, lat);
        exp_ct = ref_enc(0, p);
        chk("ab5_next_ct", a_ct, exp_ct);

        // abort in DONE
        ab = 1'b1;
        step();
        ab = 1'b0;
        chk("abd_vld", 128'(a_vld), 128'(0));
        chk("abd_rdy", 128'(a_rdy), 128'(1));
        chk("abd_ct", a_ct, exp_ct);

        // abort with start in IDLE: start wins
        p = {$urandom, $urandom, $urandom, $urandom};
        pt = p; st = 1'b1; ab = 1'b1;
        step();
        st = 1'b0; ab = 1'b0;
        chk("abi_rdy", 128'(a_rdy), 128'(0));
        chk("abi_idx", 128'(a_idx), 128'(1));
        lat = 0;
        while (!a_vld && lat < 40) begin step(); lat++; end
        chk("abi_lat", 128'(lat), 128'(10));
        chk("abi_ct", a_ct, ref_enc(0, p));
        ack10("abi_ack");

        // async reset at round 7, between clock edges
        pt = {$urandom, $urandom, $urandom, $urandom};
        st = 1'b1;
        step();
        st = 1'b0;
        n = 0;
        while (a_idx != 4'd7 && n < 20) begin step(); n++; end
        chk("ar_reach", 128'(a_idx), 128'(7));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rdy", 128'(a_rdy), 128'(1));
        chk("ar_vld", 128'(a_vld), 128'(0));
        chk("ar_ct", a_ct, 128'h0);
        chk("ar_state", a_rs, 128'h0);
        chk("ar_idx", 128'(a_idx), 128'(0));
        chk("ar_fin", 128'(a_fin), 128'(0));
        step();
        step();
        p = {$urandom, $urandom, $urandom, $urandom};
        rst_n = 1'b1; pt = p; st = 1'b1;
        step();
        st = 1'b0;
        chk("ar_accept", 128'(a_rdy), 128'(0));
        lat = 0;
        while (!a_vld && lat < 40) begin step(); lat++; end
        chk("ar_lat", 128'(lat), 128'(10));
        chk("ar_next_ct", a_ct, ref_enc(0, p));
        ack10("ar_ack");

        // NR=14: FIPS-197 C.3, then a random AES-256 key
        for (int t = 0; t < 2; t++) begin
            if (t == 0) begin
                p = 128'h00112233445566778899aabbccddeeff;
                exp_ct = 128'h8ea2b7ca516745bfeafc49904b496089;
            end else begin
                expand(1, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 8);
                p = {$urandom, $urandom, $urandom, $urandom};
                exp_ct = ref_enc(1, p);
            end
            pt = p; b_st = 1'b1;
            step();
            b_st = 1'b0;
            lat = 0;
            while (!b_vld && lat < 40) begin
                chk("b_fin", 128'(b_fin), 128'(b_idx == 4'd14));
                step();
                lat++;
            end
            chk("b_lat", 128'(lat), 128'(14));
            chk("b_ct", b_ct, exp_ct);
            b_ack = 1'b1;
            step();
            b_ack = 1'b0;
            chk("b_rdy", 128'(b_rdy), 128'(1));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NR, default 10, number of cipher rounds; legal values are 10, 12 and 14 only.
REQ-002 iClk  input  1  single clock; all state updates on rising edge.
REQ-003 iRst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 iStart  input  1  request to encrypt iPlaintext; accepted only when iStart=1 and oReady=1.
REQ-005 oReady  output  1  high only in IDLE.
REQ-006 iPlaintext  input  128  input block, sampled only on the accept cycle.
REQ-007 oRoundIdx  output  4  round-key index driven to the key store.
REQ-008 iRoundKey  input  128  round key for oRoundIdx, valid combinationally in the same cycle.
REQ-009 oRndState  output  128  state driven to the round datapath.
REQ-010 oRndKey  output  128  round key driven to the round datapath; equals iRoundKey.
REQ-011 oFinalRound  output  1  final-round select to the round datapath (bypasses MixColumns).
REQ-012 iRndResult  input  128  round datapath output, combinational from oRndState/oRndKey/oFinalRound.
REQ-013 iAbort  input  1  cancels an operation in progress.
REQ-014 oValid  output  1  oCiphertext is valid.
REQ-015 oCiphertext  output  128  result block, held stable while oValid=1.
REQ-016 iAck  input  1  consumer accepts the result; meaningful only while oValid=1.

Function
REQ-017 FSM states SHALL be IDLE, ROUND and DONE, encoded in a registered state variable.
REQ-018 IDLE: oRoundIdx=0 and oFinalRound=0.
REQ-019 IDLE accept: state_reg<=iPlaintext^iRoundKey (key 0 whitening), rnd<=1, next state ROUND.
REQ-020 ROUND: oRoundIdx=rnd, oRndState=state_reg, and oFinalRound=(rnd==NR).
REQ-021 ROUND: each cycle state_reg<=iRndResult.
REQ-022 ROUND with rnd<NR: rnd<=rnd+1.
REQ-023 ROUND with rnd==NR: oCiphertext<=iRndResult, next state DONE; exactly one cycle per round.
REQ-024 Latency: accept at edge T SHALL give oValid=1 after edge T+NR, i.e. NR+1 cycles; no bubbles between rounds.
REQ-025 DONE: oValid=1, and oCiphertext SHALL not change.
REQ-026 DONE with iAck=1: next state IDLE; oValid falls and oReady rises on the following cycle.
REQ-027 Without iAck, DONE SHALL hold indefinitely (backpressure).
REQ-028 iStart while oReady=0 SHALL be ignored, not queued.
REQ-029 iAbort=1 in ROUND or DONE: next state IDLE; oValid=0 next cycle; oCiphertext keeps its last value.
REQ-030 iAbort in IDLE SHALL be ignored; iAbort=1 with iStart=1 in IDLE: the start is accepted.
REQ-031 iAbort and iAck both high in DONE: next state IDLE (same result either way).
REQ-032 rnd SHALL be a 4-bit counter that never exceeds NR and never wraps.
REQ-033 oRndKey SHALL equal iRoundKey in all states.

Reset
REQ-034 While iRst_n=0, outputs SHALL be: state=IDLE, oReady=1, oValid=0, oCiphertext=0, state_reg=0 (so oRndState=0), rnd=0, oRoundIdx=0, oFinalRound=0.
REQ-035 Reset asserted mid-operation SHALL discard the operation with no oValid pulse; after deassertion the block is IDLE and accepts iStart on the first clock edge.

Verification
REQ-036 FIPS-197 C.1 with NR=10, real round datapath and round-key ROM: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> oCiphertext 69c4e0d86a7b0430d8cdb78070b4c55a; oValid 11 cycles after accept; oRoundIdx sequence 0,1..10; oFinalRound high only when oRoundIdx=10.
REQ-037 Back-to-back operation with iAck tied high: second iStart accepted one cycle after oValid falls; both results correct.
REQ-038 iAck held low for 20 cycles in DONE: oValid and oCiphertext stable for all 20 cycles; iStart pulses during DONE ignored.
REQ-039 iAbort at round 5: IDLE next cycle, no oValid; a following new operation produces the correct ciphertext.
REQ-040 Async reset asserted at round 7 between clock edges: outputs reach reset values immediately; no oValid after release.
REQ-041 NR=14 with the FIPS-197 C.3 vector (key 000102...1f) -> oCiphertext 8ea2b7ca516745bfeafc49904b496089; oValid 15 cycles after accept.
